lfsr_deserializer: RTL
======================

# lfsr_deserializer

Serial-to-parallel collector directly downstream of the team's 8-bit LFSR generator. It accepts the generator's LSB-first serial bit stream, assembles WIDTH-bit words, and presents each word on a valid/ready parallel interface. A double buffer (shift register plus output register) lets the next word fill while the consumer drains the current one. Back-pressure is signalled upstream through `ser_ready`.

## Interface
- `WIDTH`, default 8: bits per word; legal range 2..32.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `ser_in`  input  1  serial data bit.
- `ser_valid`  input  1  `ser_in` carries a new bit this cycle.
- `ser_ready`  output  1  block can accept a bit this cycle.
- `flush`  input  1  discard the partially assembled word.
- `par_data`  output  WIDTH  assembled word; first received bit is at bit 0.
- `par_valid`  output  1  `par_data` is valid.
- `par_ready`  input  1  consumer accepts `par_data`.
- `par_parity`  output  1  XOR of `par_data` bits; present only with `LFSR_DESER_PARITY_EN`.

## Operation
- Bit accept: a bit is accepted when `ser_valid && ser_ready`. On accept, the shift register takes `{ser_in, sh[WIDTH-1:1]}`, so the bits arrive LSB first. The bit counter `cnt` (width `$clog2(WIDTH)`) then increments.
- State machine has two states: FILL and WAIT.
- FILL:
  - `ser_ready` = 1.
  - When the WIDTH-th bit is accepted (`cnt == WIDTH-1`), the completed word goes to the output register if that register is empty or is being drained this cycle (`par_valid && par_ready`). Then `par_valid` <= 1, `cnt` <= 0, and the state stays FILL.
  - Otherwise the word is held in the shift register and the state goes to WAIT.
- WAIT:
  - `ser_ready` = 0.
  - When `par_valid && par_ready`, the output register loads the shift register, `par_valid` stays 1, `cnt` <= 0, and the state returns to FILL.
- Output drain: `par_valid && par_ready` with no new load clears `par_valid`.
- `par_data` and `par_valid` are stable while `par_valid && !par_ready`.
- Flush:
  - In FILL, `flush` clears `cnt`. The shift contents become don't-care, and any bit presented in the same cycle is dropped (flush wins).
  - In WAIT, `flush` discards the held word and returns to FILL with `cnt` = 0.
  - `flush` never affects the output register.
- Upstream contract: `ser_valid` must be asserted only on cycles that present a fresh bit. The generator's `valid` is sticky, so integration qualifies it with the registered shift-enable.

## Timing
- Reset values: `par_data` = 0, `par_valid` = 0, `par_parity` = 0, `cnt` = 0, state = FILL, and `ser_ready` = 1 in the first cycle after reset.
- Latency: `par_valid` rises on the edge that accepts the WIDTH-th bit, so it is visible 1 cycle after that bit is presented.
- Throughput: with `par_ready` held high, one word per WIDTH accepted bits and no stall cycles.
- Stall: if a second word completes while the first is still undrained, `ser_ready` drops on the next cycle. `ser_ready` rises again the cycle after the drain handshake.
- Simultaneous drain and WIDTH-th bit: the new word loads and `par_valid` stays 1, with no bubble.
- `rst` mid-word or mid-WAIT: all state returns to reset values on the next edge, and partial and held words are lost.
- `ser_ready` is combinational from state only, never from `ser_valid`.

## Configuration
- `LFSR_DESER_PARITY_EN`:
  - Defined: `par_parity` port exists and is registered together with `par_data` as `^word`, with the same hold and reset behaviour.
  - Undefined: the port and its logic are absent.

## Test plan
- Basic word: WIDTH=8, bits 1,0,1,1,0,0,1,0 with `par_ready`=1. Required: `par_data`=8'h4D and `par_valid` high for 1 cycle. With parity enabled, `par_parity`=0.
- Streaming: 4 back-to-back words with continuous `ser_valid` and `par_ready`=1. Required: `ser_ready` never drops, and `par_valid` pulses every 8 cycles with the correct words in order.
- Back-pressure: `par_ready`=0 while 16 bits are sent. Required: the first word is held stable, `ser_ready`=0 after bit 16, and no bits are lost. Raising `par_ready` drains word 1, then word 2 one cycle later.
- Flush: 5 bits then `flush` asserted with a bit presented in the same cycle, then 8 bits forming 8'hA5. Required: output is 8'hA5 only, and the partial word is never emitted.
- Reset mid-operation: assert `rst` in WAIT. Required: the next cycle shows `par_valid`=0, `ser_ready`=1, `par_data`=0, and the next 8 bits form a clean word.
- Generator integration: connect the LFSR generator with seed 8'hB4 and shift 8 bits. Required: `par_data` equals the bit sequence from the generator reference model, LSB first.

Source files
------------

// File: rtl/lfsr_deserializer.sv
// Serial-to-parallel collector for the LFSR bit stream: LSB-first bits in, WIDTH-bit words out on valid/ready.
// Optional registered word parity on par_parity when LFSR_DESER_PARITY_EN is defined.
module lfsr_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             ser_valid,
  output logic             ser_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] par_data,
  output logic             par_valid,
  input  logic             par_ready
`ifdef LFSR_DESER_PARITY_EN
  ,
  output logic             par_parity
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    FILL = 1'b0,
    WAIT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] sh_next;
  logic             drain;

  assign sh_next = {ser_in, sh_q[WIDTH-1:1]};
  assign drain   = vld_q && par_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    out_d     = out_q;
    vld_d     = vld_q;
    ser_ready = 1'b0;

    if (drain) begin
      vld_d = 1'b0;
    end

    unique case (state_q)
      FILL: begin
        ser_ready = 1'b1;
        // Flush wins over a bit presented in the same cycle.
        if (flush) begin
          cnt_d = '0;
        end else if (ser_valid) begin
          sh_d = sh_next;
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (!vld_q || par_ready) begin
              out_d = sh_next;
              vld_d = 1'b1;
            end else begin
              state_d = WAIT;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WAIT: begin
        // Held word lives in sh_q until the output register frees up.
        if (flush) begin
          state_d = FILL;
          cnt_d   = '0;
        end else if (drain) begin
          out_d   = sh_q;
          vld_d   = 1'b1;
          state_d = FILL;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    sh_q <= sh_d;
  end

  assign par_data  = out_q;
  assign par_valid = vld_q;

`ifdef LFSR_DESER_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^out_d;
    end
  end

  assign par_parity = parity_q;
`endif

endmodule
